// File: rtl/issueque_int_pkg.sv
// Shared constants for the integer issue path: default tag/data widths,
// opcode width and the ALU opcode encodings used by issue/issueint.
package issueque_int_pkg;

  localparam int OPC_W      = 6;
  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  localparam logic [OPC_W-1:0] OPC_ADD = 6'h01;
  localparam logic [OPC_W-1:0] OPC_SUB = 6'h02;
  localparam logic [OPC_W-1:0] OPC_AND = 6'h03;
  localparam logic [OPC_W-1:0] OPC_OR  = 6'h04;
  localparam logic [OPC_W-1:0] OPC_XOR = 6'h05;
  localparam logic [OPC_W-1:0] OPC_SLT = 6'h06;

endpackage

// File: rtl/issueque_int_entry.sv
// One issue-queue slot: storage plus CDB wakeup compare/capture for both
// sources. The wk_* outputs are the slot contents with this cycle's
// broadcast applied, so a younger slot shifting down keeps the wakeup.
// Optional: ISSUEQUE_DISPATCH_BYPASS_EN applies the broadcast to load data.
module issueque_entry
  import issueque_int_pkg::*;
#(
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [OPC_W-1:0]  ld_opcode,
  input  logic [TAG_W-1:0]  ld_rdtag,
  input  logic              ld_rs_v,
  input  logic [TAG_W-1:0]  ld_rs_tag,
  input  logic [DATA_W-1:0] ld_rs_data,
  input  logic              ld_rt_v,
  input  logic [TAG_W-1:0]  ld_rt_tag,
  input  logic [DATA_W-1:0] ld_rt_data,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              valid,
  output logic              ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [TAG_W-1:0]  rdtag,
  output logic [TAG_W-1:0]  rs_tag,
  output logic [DATA_W-1:0] rs_data,
  output logic [TAG_W-1:0]  rt_tag,
  output logic [DATA_W-1:0] rt_data,
  output logic              wk_rs_v,
  output logic [DATA_W-1:0] wk_rs_data,
  output logic              wk_rt_v,
  output logic [DATA_W-1:0] wk_rt_data
);

  logic rs_v, rt_v;
  logic rs_hit, rt_hit, ld_rs_hit, ld_rt_hit;

  function automatic logic wake_hit(input logic src_v, input logic [TAG_W-1:0] src_tag,
                                    input logic bus_v, input logic [TAG_W-1:0] bus_tag);
    return bus_v && !src_v && (src_tag == bus_tag);
  endfunction

  // Wakeup of held sources and (optionally) of the incoming load sources
  always_comb begin
    rs_hit     = wake_hit(rs_v, rs_tag, cdb_valid, cdb_tag);
    rt_hit     = wake_hit(rt_v, rt_tag, cdb_valid, cdb_tag);
    wk_rs_v    = rs_v | rs_hit;
    wk_rt_v    = rt_v | rt_hit;
    wk_rs_data = rs_hit ? cdb_data : rs_data;
    wk_rt_data = rt_hit ? cdb_data : rt_data;
`ifdef ISSUEQUE_DISPATCH_BYPASS_EN
    ld_rs_hit  = wake_hit(ld_rs_v, ld_rs_tag, cdb_valid, cdb_tag);
    ld_rt_hit  = wake_hit(ld_rt_v, ld_rt_tag, cdb_valid, cdb_tag);
`else
    ld_rs_hit  = 1'b0;
    ld_rt_hit  = 1'b0;
`endif
  end

  assign ready = valid & rs_v & rt_v;

  // Slot occupancy: the only state that needs reset
  always_ff @(posedge clk) begin
    if (!reset)     valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
  end

  // Payload: take load fields, otherwise keep contents with wakeup applied
  always_ff @(posedge clk) begin
    if (load) begin
      opcode  <= ld_opcode;
      rdtag   <= ld_rdtag;
      rs_tag  <= ld_rs_tag;
      rt_tag  <= ld_rt_tag;
      rs_v    <= ld_rs_v | ld_rs_hit;
      rt_v    <= ld_rt_v | ld_rt_hit;
      rs_data <= ld_rs_hit ? cdb_data : ld_rs_data;
      rt_data <= ld_rt_hit ? cdb_data : ld_rt_data;
    end else begin
      rs_v    <= wk_rs_v;
      rt_v    <= wk_rt_v;
      rs_data <= wk_rs_data;
      rt_data <= wk_rt_data;
    end
  end

endmodule

// File: rtl/issueque_int.sv
// Integer issue queue: age-ordered shifting queue (slot 0 oldest) that
// snoops the CDB for pending sources and presents the oldest ready op.
// Optional: ISSUEQUE_DISPATCH_BYPASS_EN (same-cycle CDB capture on dispatch).
module issueque_int
  import issueque_int_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_en,
  input  logic [OPC_W-1:0]  dispatch_opcode,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rsvalid,
  input  logic              dispatch_rtvalid,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  output logic              queue_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_flush,
  output logic              issueint_ready,
  output logic [OPC_W-1:0]  issueint_opcode,
  output logic [DATA_W-1:0] issueint_rsdata,
  output logic [DATA_W-1:0] issueint_rtdata,
  output logic [TAG_W-1:0]  issueint_rdtag,
  input  logic              issueint_equeueint_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              s_valid [DEPTH];
  logic              s_ready [DEPTH];
  logic [OPC_W-1:0]  s_opcode[DEPTH];
  logic [TAG_W-1:0]  s_rdtag [DEPTH];
  logic [TAG_W-1:0]  s_rstag [DEPTH];
  logic [TAG_W-1:0]  s_rttag [DEPTH];
  logic [DATA_W-1:0] s_rsdata[DEPTH];
  logic [DATA_W-1:0] s_rtdata[DEPTH];
  logic              w_rsv   [DEPTH];
  logic              w_rtv   [DEPTH];
  logic [DATA_W-1:0] w_rsdata[DEPTH];
  logic [DATA_W-1:0] w_rtdata[DEPTH];

  logic [CNT_W-1:0] count, count_nxt, tail;
  logic [IDX_W-1:0] sel;
  logic             issue_fire, dispatch_fire;

  // Select: lowest-index ready slot drives the issue port, zeros otherwise
  always_comb begin
    issueint_ready  = 1'b0;
    sel             = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (s_ready[i]) begin
        issueint_ready = 1'b1;
        sel            = IDX_W'(i);
      end
    end
    issueint_opcode = issueint_ready ? s_opcode[sel] : '0;
    issueint_rdtag  = issueint_ready ? s_rdtag[sel]  : '0;
    issueint_rsdata = issueint_ready ? s_rsdata[sel] : '0;
    issueint_rtdata = issueint_ready ? s_rtdata[sel] : '0;
  end

  assign issue_fire    = issueint_equeueint_done & issueint_ready;
  assign dispatch_fire = dispatch_en & ~queue_full;
  assign tail          = count - CNT_W'(issue_fire);
  assign count_nxt     = cdb_flush ? '0 : tail + CNT_W'(dispatch_fire);

  // Occupancy count and registered full flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      count      <= '0;
      queue_full <= 1'b0;
    end else begin
      count      <= count_nxt;
      queue_full <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic              load, clear, shift, nb_valid;
    logic [OPC_W-1:0]  ld_opcode;
    logic [TAG_W-1:0]  ld_rdtag, ld_rs_tag, ld_rt_tag;
    logic              ld_rs_v, ld_rt_v;
    logic [DATA_W-1:0] ld_rs_data, ld_rt_data;

    assign shift = issue_fire && (IDX_W'(i) >= sel);
    if (i + 1 < DEPTH) begin : g_nb
      assign nb_valid = s_valid[i+1];
    end else begin : g_last
      assign nb_valid = 1'b0;
    end

    // Slot next-state: flush, dispatch into tail, shift from neighbour, or hold
    always_comb begin
      load       = 1'b0;
      clear      = 1'b0;
      ld_opcode  = dispatch_opcode;
      ld_rdtag   = dispatch_rdtag;
      ld_rs_v    = dispatch_rsvalid;
      ld_rs_tag  = dispatch_rstag;
      ld_rs_data = dispatch_rsdata;
      ld_rt_v    = dispatch_rtvalid;
      ld_rt_tag  = dispatch_rttag;
      ld_rt_data = dispatch_rtdata;
      if (cdb_flush) begin
        clear = 1'b1;
      end else if (dispatch_fire && (tail == CNT_W'(i))) begin
        load = 1'b1;
      end else if (shift) begin
        if (nb_valid) begin
          load       = 1'b1;
          ld_opcode  = s_opcode[(i+1) % DEPTH];
          ld_rdtag   = s_rdtag[(i+1) % DEPTH];
          ld_rs_v    = w_rsv[(i+1) % DEPTH];
          ld_rs_tag  = s_rstag[(i+1) % DEPTH];
          ld_rs_data = w_rsdata[(i+1) % DEPTH];
          ld_rt_v    = w_rtv[(i+1) % DEPTH];
          ld_rt_tag  = s_rttag[(i+1) % DEPTH];
          ld_rt_data = w_rtdata[(i+1) % DEPTH];
        end else begin
          clear = 1'b1;
        end
      end
    end

    issueque_entry #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_entry (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .clear      (clear),
      .ld_opcode  (ld_opcode),
      .ld_rdtag   (ld_rdtag),
      .ld_rs_v    (ld_rs_v),
      .ld_rs_tag  (ld_rs_tag),
      .ld_rs_data (ld_rs_data),
      .ld_rt_v    (ld_rt_v),
      .ld_rt_tag  (ld_rt_tag),
      .ld_rt_data (ld_rt_data),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .valid      (s_valid[i]),
      .ready      (s_ready[i]),
      .opcode     (s_opcode[i]),
      .rdtag      (s_rdtag[i]),
      .rs_tag     (s_rstag[i]),
      .rs_data    (s_rsdata[i]),
      .rt_tag     (s_rttag[i]),
      .rt_data    (s_rtdata[i]),
      .wk_rs_v    (w_rsv[i]),
      .wk_rs_data (w_rsdata[i]),
      .wk_rt_v    (w_rtv[i]),
      .wk_rt_data (w_rtdata[i])
    );
  end

endmodule
